softmax_normalizer: RTL and testbench

Sequential softmax normalization stage that sits directly downstream of the combinational fixed-point exponential unit. It collects a vector of VEC_LEN exponentials over a valid/ready stream and accumulates their sum. It then divides each buffered element by that sum with a bit-serial divider and streams the normalized probabilities out in the same signed Q(INT_WIDTH).(FRAC_WIDTH) format.

---
 rtl/softmax_normalizer_pkg.sv | 25 ++
 rtl/softmax_normalizer_if.sv | 33 +++
 rtl/softmax_normalizer_divider.sv | 92 +++++++++
 rtl/softmax_normalizer.sv | 157 +++++++++++++++
 tb/tb_softmax_normalizer.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/softmax_normalizer_pkg.sv
// softmax_pkg: shared definitions for the softmax normalization stage.
//   - state_t     : top-level sequencer states (COLLECT, DIVIDE, EMIT)
//   - TOTAL_WIDTH : width of one Q(INT).(FRAC) sample at the default format
//   - SUM_WIDTH   : width of the running vector sum (cannot overflow)
//   - DIV_CYCLES  : cycles per bit-serial division (one quotient bit per cycle)
//   - ONE         : the value 1.0 in the default Q format
package softmax_pkg;

  localparam int DEF_INT_WIDTH  = 8;
  localparam int DEF_FRAC_WIDTH = 8;
  localparam int DEF_VEC_LEN    = 8;

  localparam int TOTAL_WIDTH = DEF_INT_WIDTH + DEF_FRAC_WIDTH;
  localparam int SUM_WIDTH   = TOTAL_WIDTH + $clog2(DEF_VEC_LEN);
  localparam int DIV_CYCLES  = TOTAL_WIDTH + DEF_FRAC_WIDTH;

  localparam logic [TOTAL_WIDTH-1:0] ONE = TOTAL_WIDTH'(1) << DEF_FRAC_WIDTH;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    DIVIDE  = 2'd1,
    EMIT    = 2'd2
  } state_t;

endpackage

// File: rtl/softmax_normalizer_if.sv
// softmax_normalizer_if: input and output valid/ready streams of the
// softmax normalizer.
//   in_valid/in_ready/in_data              : exponentials into the block
//   out_valid/out_ready/out_data           : normalized probabilities out
//   out_last                               : final element of a vector
//   out_zero_sum                           : vector sum was zero
// Modports: slave = the normalizer, master = the upstream/downstream side.
interface softmax_normalizer_if
  import softmax_pkg::*;
#(
  parameter int DATA_WIDTH = TOTAL_WIDTH
) ();

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;
  logic                  out_zero_sum;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, out_zero_sum
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_zero_sum
  );

endinterface

// File: rtl/softmax_normalizer_divider.sv
// seq_divider: unsigned restoring divider, one quotient bit per clock.
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : load numerator/denominator; the first quotient bit is
//                  produced on this same edge
//   numerator    : NUM_WIDTH-bit dividend
//   denominator  : DEN_WIDTH-bit divisor (must be non-zero)
//   busy         : iterations remaining
//   done         : one-cycle pulse, quotient valid from this cycle on
//   quotient     : low QUO_WIDTH bits of the truncated quotient
// A division occupies NUM_WIDTH edges from start to the edge raising done.
module seq_divider #(
  parameter int NUM_WIDTH = 24,
  parameter int DEN_WIDTH = 19,
  parameter int QUO_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [NUM_WIDTH-1:0] numerator,
  input  logic [DEN_WIDTH-1:0] denominator,
  output logic                 busy,
  output logic                 done,
  output logic [QUO_WIDTH-1:0] quotient
);

  localparam int CNT_W = $clog2(NUM_WIDTH + 1);

  // quo_reg shifts the dividend out of its MSB while quotient bits enter
  // at its LSB, so after NUM_WIDTH steps it holds the whole quotient.
  logic [NUM_WIDTH-1:0] quo_reg;
  logic [DEN_WIDTH-1:0] rem_reg;
  logic [DEN_WIDTH-1:0] den_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic                 busy_reg;
  logic                 done_reg;

  logic [NUM_WIDTH-1:0] quo_src;
  logic [DEN_WIDTH-1:0] rem_src;
  logic [DEN_WIDTH-1:0] den_src;
  logic [DEN_WIDTH:0]   rem_shift;
  logic                 ge;
  logic [DEN_WIDTH-1:0] rem_next;
  logic [NUM_WIDTH-1:0] quo_next;

  // One restoring step, fed either from the fresh operands (start) or
  // from the running state.
  always_comb begin
    quo_src   = start ? numerator   : quo_reg;
    rem_src   = start ? '0          : rem_reg;
    den_src   = start ? denominator : den_reg;
    rem_shift = {rem_src, quo_src[NUM_WIDTH-1]};
    ge        = rem_shift >= {1'b0, den_src};
    // The remainder is always below the divisor, so the top bit of the
    // difference is zero and dropping it is exact.
    rem_next  = ge ? DEN_WIDTH'(rem_shift - {1'b0, den_src})
                   : rem_shift[DEN_WIDTH-1:0];
    quo_next  = {quo_src[NUM_WIDTH-2:0], ge};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_reg  <= '0;
      rem_reg  <= '0;
      den_reg  <= '0;
      cnt_reg  <= '0;
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (start) begin
        quo_reg  <= quo_next;
        rem_reg  <= rem_next;
        den_reg  <= denominator;
        cnt_reg  <= CNT_W'(NUM_WIDTH - 1);
        busy_reg <= 1'b1;
      end else if (busy_reg) begin
        quo_reg <= quo_next;
        rem_reg <= rem_next;
        cnt_reg <= cnt_reg - CNT_W'(1);
        if (cnt_reg == CNT_W'(1)) begin
          busy_reg <= 1'b0;
          done_reg <= 1'b1;
        end
      end
    end
  end

  assign busy     = busy_reg;
  assign done     = done_reg;
  assign quotient = quo_reg[QUO_WIDTH-1:0];

endmodule

// File: rtl/softmax_normalizer.sv
// softmax_normalizer: collects VEC_LEN non-negative exponentials, sums
// them, then emits each element divided by the sum in the same signed
// Q(INT_WIDTH).(FRAC_WIDTH) format.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : softmax_normalizer_if.slave (input and output streams)
// Phases: COLLECT (accept a full vector), then DIVIDE/EMIT per element.
// A vector is never overlapped with the next one.
module softmax_normalizer
  import softmax_pkg::*;
#(
  parameter int INT_WIDTH  = DEF_INT_WIDTH,
  parameter int FRAC_WIDTH = DEF_FRAC_WIDTH,
  parameter int VEC_LEN    = DEF_VEC_LEN
) (
  input  logic                 clk,
  input  logic                 rst_n,
  softmax_normalizer_if.slave  bus
);

  localparam int DATA_W = INT_WIDTH + FRAC_WIDTH;
  localparam int ACC_W  = DATA_W + $clog2(VEC_LEN);
  localparam int NUM_W  = DATA_W + FRAC_WIDTH;
  localparam int IDX_W  = $clog2(VEC_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_LEN - 1);

  state_t              state_reg;
  logic [IDX_W-1:0]    idx_reg;
  logic [ACC_W-1:0]    sum_reg;
  logic                launched_reg;
  logic                in_ready_reg;
  logic                out_valid_reg;
  logic [DATA_W-1:0]   out_data_reg;
  logic                out_last_reg;
  logic                out_zero_sum_reg;

  logic [DATA_W-1:0]   buffer [VEC_LEN];

  logic                accept;
  logic                is_last;
  logic [DATA_W-1:0]   clamped;
  logic [NUM_W-1:0]    numerator;
  logic                div_start;
  logic                div_busy;
  logic                div_done;
  logic [DATA_W-1:0]   div_quotient;

  assign accept    = (state_reg == COLLECT) && bus.in_valid && in_ready_reg;
  assign is_last   = (idx_reg == LAST_IDX);
  // Negative exponentials can only come from upstream rounding; treat as 0.
  assign clamped   = bus.in_data[DATA_W-1] ? '0 : bus.in_data;
  assign numerator = {buffer[idx_reg], {FRAC_WIDTH{1'b0}}};
  // Launch exactly once per DIVIDE visit; a zero sum bypasses the divider.
  assign div_start = (state_reg == DIVIDE) && (sum_reg != '0)
                     && !launched_reg && !div_busy;

  for (genvar gi = 0; gi < VEC_LEN; gi++) begin : g_buf
    always_ff @(posedge clk) begin
      if (accept && (idx_reg == IDX_W'(gi))) begin
        buffer[gi] <= clamped;
      end
    end
  end

  seq_divider #(
    .NUM_WIDTH (NUM_W),
    .DEN_WIDTH (ACC_W),
    .QUO_WIDTH (DATA_W)
  ) u_div (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (div_start),
    .numerator   (numerator),
    .denominator (sum_reg),
    .busy        (div_busy),
    .done        (div_done),
    .quotient    (div_quotient)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= COLLECT;
      idx_reg          <= '0;
      sum_reg          <= '0;
      launched_reg     <= 1'b0;
      in_ready_reg     <= 1'b0;
      out_valid_reg    <= 1'b0;
      out_data_reg     <= '0;
      out_last_reg     <= 1'b0;
      out_zero_sum_reg <= 1'b0;
    end else begin
      case (state_reg)
        COLLECT: begin
          in_ready_reg <= 1'b1;
          if (accept) begin
            sum_reg <= sum_reg + ACC_W'(clamped);
            if (is_last) begin
              idx_reg      <= '0;
              in_ready_reg <= 1'b0;
              launched_reg <= 1'b0;
              state_reg    <= DIVIDE;
            end else begin
              idx_reg <= idx_reg + IDX_W'(1);
            end
          end
        end

        DIVIDE: begin
          if (div_start) begin
            launched_reg <= 1'b1;
          end
          if (sum_reg == '0) begin
            out_data_reg     <= '0;
            out_valid_reg    <= 1'b1;
            out_last_reg     <= is_last;
            out_zero_sum_reg <= 1'b1;
            state_reg        <= EMIT;
          end else if (div_done) begin
            // Quotient is at most 1.0, so its low DATA_W bits are exact.
            out_data_reg     <= div_quotient;
            out_valid_reg    <= 1'b1;
            out_last_reg     <= is_last;
            out_zero_sum_reg <= 1'b0;
            state_reg        <= EMIT;
          end
        end

        EMIT: begin
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            launched_reg  <= 1'b0;
            if (is_last) begin
              idx_reg      <= '0;
              sum_reg      <= '0;
              in_ready_reg <= 1'b1;
              state_reg    <= COLLECT;
            end else begin
              idx_reg   <= idx_reg + IDX_W'(1);
              state_reg <= DIVIDE;
            end
          end
        end

        default: begin
          state_reg <= COLLECT;
        end
      endcase
    end
  end

  assign bus.in_ready     = in_ready_reg;
  assign bus.out_valid    = out_valid_reg;
  assign bus.out_data     = out_data_reg;
  assign bus.out_last     = out_last_reg;
  assign bus.out_zero_sum = out_zero_sum_reg;

endmodule

// File: tb/tb_softmax_normalizer.sv
// Directed, table-driven bench for softmax_normalizer: vector results,
// latency/spacing, backpressure hold and asynchronous reset mid-vector.
module tb_softmax_normalizer;
  import softmax_pkg::*;

  typedef struct packed {
    logic [7:0][15:0] din;
    logic [7:0][15:0] expv;
    logic             zs;
    logic             gaps;
    int               stall_idx;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  softmax_normalizer_if #(.DATA_WIDTH(TOTAL_WIDTH)) bus ();

  softmax_normalizer #(
    .INT_WIDTH  (8),
    .FRAC_WIDTH (8),
    .VEC_LEN    (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   tests = 0;
  int   fails = 0;
  int   last_acc_cyc = 0;
  int   rise_cyc [8];
  int   hs_cyc   [8];
  vec_t tbl      [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  // Called at a negedge; returns at a negedge after the last accept.
  task automatic send_vector(input int v, input logic [7:0][15:0] din, input logic gaps);
    int t;
    for (int i = 0; i < 8; i++) begin
      if (gaps) begin
        bus.in_valid = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      bus.in_valid = 1'b1;
      bus.in_data  = din[i];
      t = 0;
      while (!bus.in_ready && t < 200) begin
        @(negedge clk);
        t++;
      end
      if (!bus.in_ready) begin
        chk($sformatf("vec%0d in%0d accept timeout", v, i), 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b0;
        return;
      end
      @(negedge clk);
      last_acc_cyc = cyc;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic recv_vector(input int v, input logic [7:0][15:0] expv, input logic zs,
                             input int n, input int stall_idx, input int stall_len);
    int         t;
    logic [15:0] d0;
    logic       hold_ok;
    bus.out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      t = 0;
      while (!bus.out_valid && t < 200) begin
        @(negedge clk);
        t++;
      end
      if (!bus.out_valid) begin
        chk($sformatf("vec%0d out%0d valid timeout", v, i), 32'(bus.out_valid), 32'd1);
        return;
      end
      rise_cyc[i] = cyc;
      if (i == stall_idx) begin
        bus.out_ready = 1'b0;
        d0 = bus.out_data;
        hold_ok = 1'b1;
        repeat (stall_len) begin
          @(negedge clk);
          if (!bus.out_valid || bus.out_data !== d0 || bus.in_ready !== 1'b0 ||
              bus.out_last !== 1'b0 || bus.out_zero_sum !== zs)
            hold_ok = 1'b0;
        end
        chk($sformatf("vec%0d out%0d stall hold", v, i), 32'(hold_ok), 32'd1);
        bus.out_ready = 1'b1;
      end
      $display("[TB] vec%0d out%0d data=0x%04h last=%0b zero_sum=%0b cyc=%0d",
               v, i, bus.out_data, bus.out_last, bus.out_zero_sum, cyc);
      chk($sformatf("vec%0d out%0d data", v, i), 32'(bus.out_data), 32'(expv[i]));
      chk($sformatf("vec%0d out%0d last", v, i), 32'(bus.out_last), 32'(i == 7));
      chk($sformatf("vec%0d out%0d zero_sum", v, i), 32'(bus.out_zero_sum), 32'(zs));
      @(negedge clk);
      hs_cyc[i] = cyc;
    end
  endtask

  initial begin
    int worst;
    int gap;
    int extra;

    // Vector table: inputs and hand-computed truncated quotients.
    for (int v = 0; v < 7; v++) begin
      tbl[v].din = '0;
      tbl[v].expv = '0;
      tbl[v].zs = 1'b0;
      tbl[v].gaps = 1'b0;
      tbl[v].stall_idx = -1;
    end
    for (int i = 0; i < 8; i++) begin
      tbl[0].din[i] = 16'h0100; tbl[0].expv[i] = 16'h0020;
      tbl[3].din[i] = 16'h0000; tbl[3].expv[i] = 16'h0000;
      tbl[4].din[i] = 16'hFF00; tbl[4].expv[i] = 16'h0000;
      tbl[5].din[i] = 16'h0100; tbl[5].expv[i] = 16'h0020;
    end
    for (int i = 0; i < 3; i++) begin
      tbl[1].din[i] = 16'h0100; tbl[1].expv[i] = 16'h0055;
    end
    tbl[2].din[0] = 16'h0400; tbl[2].expv[0] = 16'h0100;
    tbl[3].zs = 1'b1;
    tbl[4].zs = 1'b1;
    tbl[5].gaps = 1'b1;
    // sum = 0xA80 = 2688
    tbl[6].din[0] = 16'h0100; tbl[6].expv[0] = 16'h0018;
    tbl[6].din[1] = 16'h0200; tbl[6].expv[1] = 16'h0030;
    tbl[6].din[2] = 16'h0300; tbl[6].expv[2] = 16'h0049;
    tbl[6].din[3] = 16'h0400; tbl[6].expv[3] = 16'h0061;
    tbl[6].din[4] = 16'h0080; tbl[6].expv[4] = 16'h000C;
    tbl[6].stall_idx = 3;

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;

    repeat (3) @(negedge clk);
    chk("reset out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset out_data", 32'(bus.out_data), 32'd0);
    chk("reset out_last", 32'(bus.out_last), 32'd0);
    chk("reset out_zero_sum", 32'(bus.out_zero_sum), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready after reset", 32'(bus.in_ready), 32'd1);

    for (int v = 0; v < 7; v++) begin
      send_vector(v, tbl[v].din, tbl[v].gaps);
      recv_vector(v, tbl[v].expv, tbl[v].zs, 8, tbl[v].stall_idx, 5);
      if (tbl[v].zs) begin
        worst = 2;
        for (int i = 1; i < 8; i++) begin
          gap = hs_cyc[i] - hs_cyc[i-1];
          if (gap != 2) worst = gap;
        end
        chk($sformatf("vec%0d zero-sum spacing", v), 32'(worst), 32'd2);
      end else begin
        chk($sformatf("vec%0d first latency", v), 32'(rise_cyc[0] - last_acc_cyc),
            32'(DIV_CYCLES + 1));
        worst = DIV_CYCLES + 1;
        for (int i = 1; i < 8; i++) begin
          gap = rise_cyc[i] - hs_cyc[i-1];
          if (gap != DIV_CYCLES + 1) worst = gap;
        end
        chk($sformatf("vec%0d element latency", v), 32'(worst), 32'(DIV_CYCLES + 1));
      end
    end

    // Reset in the middle of element 4's division.
    send_vector(7, tbl[0].din, 1'b0);
    recv_vector(7, tbl[0].expv, 1'b0, 4, -1, 0);
    repeat (10) @(negedge clk);
    chk("pre-reset in_ready", 32'(bus.in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mid-reset out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid-reset out_data", 32'(bus.out_data), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-reset in_ready", 32'(bus.in_ready), 32'd1);
    send_vector(8, tbl[0].din, 1'b0);
    recv_vector(8, tbl[0].expv, 1'b0, 8, -1, 0);
    extra = 0;
    repeat (60) begin
      @(negedge clk);
      if (bus.out_valid) extra++;
    end
    chk("post-reset extra outputs", 32'(extra), 32'd0);
    chk("ONE passthrough vec2", 32'(tbl[2].expv[0]), 32'(ONE));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
